// File: rtl/adc_read_ctrl_if.sv
// Host/ADC signal bundle for adc_read_ctrl.
// The controller takes the master modport and the environment takes the slave modport.
interface adc_read_ctrl_if;
    logic        req;
    logic        abort;
    logic        adc_enable;
    logic        adc_read;
    logic        adc_conversion_complete;
    logic [15:0] adc_value;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] value;

    modport master (
        input  req, abort, adc_conversion_complete, adc_value,
        output adc_enable, adc_read, busy, done, timeout, value
    );

    modport slave (
        output req, abort, adc_conversion_complete, adc_value,
        input  adc_enable, adc_read, busy, done, timeout, value
    );
endinterface

// File: rtl/adc_read_ctrl.sv
// ADC read sequencer: power up, settle, hold read until completion/timeout/abort, recover.
// Every output comes straight from a flop loaded with its next-state value.
module adc_read_ctrl #(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    adc_read_ctrl_if.master       bus
);
    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, READ, RECOVER} state_t;

    state_t        r_state, w_state_nxt;
    logic [SW-1:0] r_settle_cnt, w_settle_cnt_nxt;
    logic [TW-1:0] r_read_cnt, w_read_cnt_nxt;
    logic          r_adc_enable, w_adc_enable_nxt;
    logic          r_adc_read, w_adc_read_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;
    logic          r_timeout, w_timeout_nxt;
    logic [15:0]   r_value, w_value_nxt;

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_settle_cnt <= '0;
            r_read_cnt   <= '0;
            r_adc_enable <= 1'b0;
            r_adc_read   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_value      <= 16'h0000;
        end else begin
            r_state      <= w_state_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
            r_read_cnt   <= w_read_cnt_nxt;
            r_adc_enable <= w_adc_enable_nxt;
            r_adc_read   <= w_adc_read_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_timeout    <= w_timeout_nxt;
            r_value      <= w_value_nxt;
        end
    end

    // Next state; in READ completion has priority over abort, abort over timeout
    always_comb begin
        w_state_nxt      = r_state;
        w_settle_cnt_nxt = r_settle_cnt;
        w_read_cnt_nxt   = r_read_cnt;
        w_done_nxt       = 1'b0;
        w_timeout_nxt    = 1'b0;
        w_value_nxt      = r_value;

        case (r_state)
            IDLE: begin
                w_settle_cnt_nxt = '0;
                w_read_cnt_nxt   = '0;
                if (bus.req) begin
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (bus.abort) begin
                    w_state_nxt = RECOVER;
                end else if (r_settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                    w_state_nxt    = READ;
                    w_read_cnt_nxt = '0;
                end else if (r_settle_cnt != '1) begin
                    w_settle_cnt_nxt = r_settle_cnt + SW'(1);
                end
            end
            READ: begin
                if (bus.adc_conversion_complete) begin
                    w_state_nxt = RECOVER;
                    w_done_nxt  = 1'b1;
                    w_value_nxt = bus.adc_value;
                end else if (bus.abort) begin
                    w_state_nxt = RECOVER;
                end else if (r_read_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nxt   = RECOVER;
                    w_timeout_nxt = 1'b1;
                end else if (r_read_cnt != '1) begin
                    w_read_cnt_nxt = r_read_cnt + TW'(1);
                end
            end
            RECOVER: begin
                w_state_nxt      = IDLE;
                w_settle_cnt_nxt = '0;
                w_read_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_adc_enable_nxt = (w_state_nxt != IDLE);
        w_adc_read_nxt   = (w_state_nxt == READ);
        w_busy_nxt       = (w_state_nxt != IDLE);
    end

    assign bus.adc_enable = r_adc_enable;
    assign bus.adc_read   = r_adc_read;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.timeout    = r_timeout;
    assign bus.value      = r_value;
endmodule

// File: tb/tb_adc_read_ctrl.sv
// Bench for adc_read_ctrl: timestamp-based reference model, per-cycle compare,
// directed scenarios with literal expectations, and a randomized regression.
module tb_adc_read_ctrl;
    localparam int unsigned S = 16;
    localparam int unsigned T = 4096;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    adc_read_ctrl_if bus ();

    adc_read_ctrl #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a conversion is described by the edge it was accepted on
    int          n         = 0;
    int          t_acc     = 0;
    bit          m_active  = 1'b0;
    bit          m_recover = 1'b0;
    logic [15:0] m_value   = 16'h0000;
    bit e_en = 0, e_rd = 0, e_busy = 0, e_done = 0, e_to = 0;

    initial begin : model
        int rel;
        forever begin
            @(posedge clk or negedge rst_n);
            e_done = 1'b0;
            e_to   = 1'b0;
            if (!rst_n) begin
                m_active  = 1'b0;
                m_recover = 1'b0;
                m_value   = 16'h0000;
            end else begin
                n++;
                if (m_recover) begin
                    m_active  = 1'b0;
                    m_recover = 1'b0;
                end else if (!m_active) begin
                    if (bus.req === 1'b1) begin
                        m_active = 1'b1;
                        t_acc    = n;
                    end
                end else begin
                    rel = n - t_acc;
                    if (rel <= int'(S)) begin
                        if (bus.abort === 1'b1) m_recover = 1'b1;
                    end else if (bus.adc_conversion_complete === 1'b1) begin
                        m_value   = bus.adc_value;
                        e_done    = 1'b1;
                        m_recover = 1'b1;
                    end else if (bus.abort === 1'b1) begin
                        m_recover = 1'b1;
                    end else if (rel - int'(S) == int'(T)) begin
                        e_to      = 1'b1;
                        m_recover = 1'b1;
                    end
                end
            end
            e_busy = m_active;
            e_en   = m_active;
            e_rd   = m_active && !m_recover && (n - t_acc >= int'(S));
        end
    end

    // Per-cycle compare plus running pulse statistics
    bit cmp_en      = 1'b0;
    int done_total  = 0;
    int to_total    = 0;
    int rd_hi_total = 0;

    initial begin : compare
        forever begin
            @(negedge clk);
            if (cmp_en && rst_n) begin
                chk("adc_enable", 32'(bus.adc_enable), 32'(e_en));
                chk("adc_read",   32'(bus.adc_read),   32'(e_rd));
                chk("busy",       32'(bus.busy),       32'(e_busy));
                chk("done",       32'(bus.done),       32'(e_done));
                chk("timeout",    32'(bus.timeout),    32'(e_to));
                chk("value",      32'(bus.value),      32'(m_value));
                if (bus.done === 1'b1)     done_total++;
                if (bus.timeout === 1'b1)  to_total++;
                if (bus.adc_read === 1'b1) rd_hi_total++;
            end
        end
    end

    // ADC device: completes cur_lat cycles after adc_read rises (0 = never)
    int          adc_lat   = 0;
    logic [15:0] adc_data  = 16'h0000;
    bit          rand_mode = 1'b0;
    bit          stray_en  = 1'b0;

    initial begin : adc_dev
        int          rd_cnt;
        int          cur_lat;
        logic [15:0] cur_data;
        rd_cnt = 0;
        cur_lat = 0;
        cur_data = 16'h0000;
        bus.adc_conversion_complete = 1'b0;
        bus.adc_value = 16'h0000;
        forever begin
            @(negedge clk);
            bus.adc_conversion_complete = 1'b0;
            bus.adc_value = 16'($urandom);
            if (!rst_n || bus.adc_read !== 1'b1) begin
                rd_cnt = 0;
                if (rst_n && stray_en && $urandom_range(0, 49) == 0)
                    bus.adc_conversion_complete = 1'b1;
            end else begin
                rd_cnt++;
                if (rd_cnt == 1) begin
                    cur_lat  = rand_mode ? int'($urandom_range(1000, 2000)) : adc_lat;
                    cur_data = rand_mode ? 16'($urandom) : adc_data;
                end
                if (cur_lat != 0 && rd_cnt == cur_lat) begin
                    bus.adc_conversion_complete = 1'b1;
                    bus.adc_value = cur_data;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", failures);
        $fatal(1, "watchdog expired");
    end

    task automatic pulse_req();
        bus.req = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
    endtask

    task automatic wait_read(output int cnt);
        cnt = 0;
        while (bus.adc_read !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk("wait_read", 32'(bus.adc_read), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while (bus.busy !== 1'b0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("wait_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin : main
        int c, d0, t0, r0;
        bus.req   = 1'b0;
        bus.abort = 1'b0;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_adc_enable", 32'(bus.adc_enable), 32'd0);
        chk("rst_adc_read",   32'(bus.adc_read),   32'd0);
        chk("rst_busy",       32'(bus.busy),       32'd0);
        chk("rst_done",       32'(bus.done),       32'd0);
        chk("rst_timeout",    32'(bus.timeout),    32'd0);
        chk("rst_value",      32'(bus.value),      32'd0);
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal conversion
        adc_lat = 1500; adc_data = 16'hA5C3; d0 = done_total;
        pulse_req();
        wait_read(c);
        chk("nom_settle_len", 32'(c), 32'd16);
        c = 0;
        while (bus.done !== 1'b1 && c < 3000) begin @(negedge clk); c++; end
        chk("nom_done", 32'(bus.done), 32'd1);
        chk("nom_latency", 32'(c), 32'd1500);
        chk("nom_value", 32'(bus.value), 32'hA5C3);
        chk("nom_busy_recover", 32'(bus.busy), 32'd1);
        @(negedge clk);
        chk("nom_busy_low", 32'(bus.busy), 32'd0);
        chk("nom_done_count", 32'(done_total - d0), 32'd1);

        // Timeout: ADC never completes
        adc_lat = 0; d0 = done_total; t0 = to_total; r0 = rd_hi_total;
        repeat (3) @(negedge clk);
        pulse_req();
        wait_idle(5000);
        chk("to_read_len", 32'(rd_hi_total - r0), 32'd4096);
        chk("to_pulses", 32'(to_total - t0), 32'd1);
        chk("to_no_done", 32'(done_total - d0), 32'd0);
        chk("to_value_kept", 32'(bus.value), 32'hA5C3);

        // Completion on the last allowed READ edge
        adc_lat = 4096; adc_data = 16'h1234; d0 = done_total; t0 = to_total;
        repeat (3) @(negedge clk);
        pulse_req();
        wait_idle(5000);
        chk("bnd_done", 32'(done_total - d0), 32'd1);
        chk("bnd_no_timeout", 32'(to_total - t0), 32'd0);
        chk("bnd_value", 32'(bus.value), 32'h1234);

        // Abort at READ cycle 500, then restart
        adc_lat = 0; d0 = done_total; t0 = to_total;
        repeat (3) @(negedge clk);
        pulse_req();
        wait_read(c);
        repeat (499) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abt_read_low", 32'(bus.adc_read), 32'd0);
        wait_idle(10);
        chk("abt_no_done", 32'(done_total - d0), 32'd0);
        chk("abt_no_timeout", 32'(to_total - t0), 32'd0);
        chk("abt_value_kept", 32'(bus.value), 32'h1234);
        adc_lat = 1000; adc_data = 16'h0F0F;
        repeat (2) @(negedge clk);
        pulse_req();
        wait_idle(3000);
        chk("abt_restart_done", 32'(done_total - d0), 32'd1);
        chk("abt_restart_value", 32'(bus.value), 32'h0F0F);

        // Completion and abort on the same edge
        adc_lat = 700; adc_data = 16'hBEEF;
        repeat (2) @(negedge clk);
        pulse_req();
        wait_read(c);
        repeat (699) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("sim_done", 32'(bus.done), 32'd1);
        chk("sim_value", 32'(bus.value), 32'hBEEF);
        wait_idle(10);

        // Second req during READ is dropped
        adc_lat = 1200; adc_data = 16'h5555; d0 = done_total;
        repeat (2) @(negedge clk);
        pulse_req();
        wait_read(c);
        repeat (100) @(negedge clk);
        pulse_req();
        wait_idle(3000);
        repeat (40) @(negedge clk);
        chk("busyreq_idle", 32'(bus.busy), 32'd0);
        chk("busyreq_one_done", 32'(done_total - d0), 32'd1);

        // Reset at READ cycle 100
        adc_lat = 0;
        pulse_req();
        wait_read(c);
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_adc_enable", 32'(bus.adc_enable), 32'd0);
        chk("mid_rst_adc_read",   32'(bus.adc_read),   32'd0);
        chk("mid_rst_busy",       32'(bus.busy),       32'd0);
        chk("mid_rst_done",       32'(bus.done),       32'd0);
        chk("mid_rst_timeout",    32'(bus.timeout),    32'd0);
        chk("mid_rst_value",      32'(bus.value),      32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        adc_lat = 1000; adc_data = 16'hC0DE; d0 = done_total;
        repeat (2) @(negedge clk);
        pulse_req();
        wait_idle(3000);
        chk("post_rst_done", 32'(done_total - d0), 32'd1);
        chk("post_rst_value", 32'(bus.value), 32'hC0DE);

        // Randomized back-to-back regression
        rand_mode = 1'b1; stray_en = 1'b1; d0 = done_total;
        for (int i = 0; i < 15000; i++) begin
            bus.req   = ($urandom_range(0, 3) != 0);
            bus.abort = ($urandom_range(0, 2999) == 0);
            @(negedge clk);
        end
        bus.req = 1'b0; bus.abort = 1'b0;
        wait_idle(5000);
        chk("regr_dones_seen", 32'(done_total - d0 > 3), 32'd1);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adc_read_ctrl.md
ADC_READ_CTRL -- requirements
Module: adc_read_ctrl

Interface
- REQ-001 SHALL have parameter SETTLE_CYCLES, default 16, meaning cycles adc_enable is held high before adc_read rises; legal range >= 1.
- REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning the maximum number of cycles adc_read is held high awaiting completion; legal range >= 2.
- REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
- REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
- REQ-005 SHALL have port req, input, 1 bit: start a conversion, sampled high for one cycle.
- REQ-006 SHALL have port abort, input, 1 bit: cancel an in-progress conversion.
- REQ-007 SHALL have port adc_enable, output, 1 bit: powers up the ADC.
- REQ-008 SHALL have port adc_read, output, 1 bit: the rising edge starts a conversion; held high until completion, timeout or abort.
- REQ-009 SHALL have port adc_conversion_complete, input, 1 bit: single-cycle pulse from the ADC.
- REQ-010 SHALL have port adc_value, input, 16 bits: the ADC result, valid when adc_conversion_complete is high.
- REQ-011 SHALL have port busy, output, 1 bit: high whenever state != IDLE.
- REQ-012 SHALL have port done, output, 1 bit: single-cycle pulse that marks value as newly updated.
- REQ-013 SHALL have port timeout, output, 1 bit: single-cycle pulse that marks a conversion as timed out.
- REQ-014 SHALL have port value, output, 16 bits: last successfully captured ADC result.

Function
- REQ-015 SHALL implement states IDLE, SETTLE, READ and RECOVER, with all outputs registered.
- REQ-016 IDLE: adc_enable=0 and adc_read=0; req sampled high -> SETTLE, and adc_enable goes high after that edge.
- REQ-017 SETTLE: adc_enable=1 and adc_read=0; after exactly SETTLE_CYCLES edges in SETTLE -> READ, and adc_read goes high after the edge at which req+SETTLE_CYCLES is reached.
- REQ-018 READ: adc_enable=1 and adc_read=1, with a cycle counter that starts at 0 on entry.
- REQ-019 READ: adc_conversion_complete sampled high -> value<=adc_value, done=1 for one cycle, adc_read=0, all after that same edge; next state RECOVER.
- REQ-020 READ: if completion is not seen by the TIMEOUT_CYCLES-th edge -> timeout=1 for one cycle, adc_read=0, next state RECOVER, and value is unchanged.
- REQ-021 RECOVER: adc_read=0 and adc_enable=1 for exactly one cycle, then -> IDLE with adc_enable=0; this guarantees adc_read is low for at least 2 cycles between conversions.
- REQ-022 abort sampled high in SETTLE or READ -> RECOVER, with no done and no timeout, and value unchanged.
- REQ-023 Simultaneous events in READ SHALL resolve as follows: completion beats timeout, and completion beats abort.
- REQ-024 req while busy=1 SHALL be ignored, with no queuing.
- REQ-025 abort in IDLE or RECOVER SHALL be ignored.
- REQ-026 adc_conversion_complete outside READ SHALL be ignored.
- REQ-027 done and timeout SHALL never be high in the same cycle.
- REQ-028 Each of done and timeout SHALL never be high for 2 consecutive cycles.
- REQ-029 value SHALL change only on a done pulse and SHALL otherwise hold.
- REQ-030 The READ counter SHALL be ceil(log2(TIMEOUT_CYCLES+1)) bits wide and SHALL saturate with no wrap.
- REQ-031 The SETTLE counter SHALL be sized likewise from SETTLE_CYCLES.

Reset
- REQ-032 rst_n low SHALL immediately force, asynchronously: state=IDLE, adc_enable=0, adc_read=0, busy=0, done=0, timeout=0, value=16'h0000, and counters=0.
- REQ-033 Reset asserted mid-conversion SHALL drop adc_read and adc_enable at once, with no done or timeout pulse.
- REQ-034 After rst_n deasserts, the first req SHALL start a normal sequence.

Verification
- REQ-035 Nominal: SETTLE_CYCLES=16, req at edge 0, ADC model completes 1500 cycles after adc_read rises with adc_value=16'hA5C3 -> adc_read rises after edge 16, done pulses once, value=16'hA5C3, busy low 2 edges after completion.
- REQ-036 Timeout: TIMEOUT_CYCLES=4096, ADC never completes -> adc_read is high for exactly 4096 cycles, timeout pulses once, value keeps its prior value, then IDLE.
- REQ-037 Boundary: completion on the 4096th READ edge -> done=1, timeout=0, value captured.
- REQ-038 Abort: abort at READ cycle 500 -> adc_read is low next cycle, there is no done or timeout pulse, and a following req restarts the sequence.
- REQ-039 Simultaneous: completion and abort on the same edge -> done=1 and value captured.
- REQ-040 Busy req: a second req during READ is ignored, with exactly one done.
- REQ-041 Reset: rst_n low at READ cycle 100 -> all outputs 0 immediately and value=0.
- REQ-042 Random regression: back-to-back reqs with completion latency uniform over 1000..2000 -> every done value matches the ADC model's last valid value, and adc_read is never re-raised while the model is busy.
